// File: rtl/alu_pkg.sv
// alu_pkg: shared unit-select codes, logic sub-function codes and sequencer FSM states.
// Revision 1.0
`default_nettype none

package alu_pkg;

    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOG   = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;

    localparam logic [1:0] LOG_AND  = 2'b00;
    localparam logic [1:0] LOG_OR   = 2'b01;
    localparam logic [1:0] LOG_NAND = 2'b10;
    localparam logic [1:0] LOG_NOR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command and result handshakes of the ALU sequencer.
// Optional ALU_SEQ_STATUS_EN adds res_zero/res_err. Revision 1.0
`default_nettype none

interface alu_op_sequencer_if #(
    parameter int width = 16
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_fun;
    logic [width-1:0] cmd_a;
    logic [width-1:0] cmd_b;
    logic             res_valid;
    logic             res_ready;
    logic [width-1:0] res_data;
`ifdef ALU_SEQ_STATUS_EN
    logic             res_zero;
    logic             res_err;

    modport master (
        output cmd_valid, cmd_fun, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_zero, res_err
    );
    modport slave (
        input  cmd_valid, cmd_fun, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_zero, res_err
    );
`else
    modport master (
        output cmd_valid, cmd_fun, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data
    );
    modport slave (
        input  cmd_valid, cmd_fun, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data
    );
`endif

endinterface

`default_nettype wire

// File: rtl/alu_unit_decode.sv
// alu_unit_decode: 2-bit unit select to one-hot enable, gated by issue.
// Revision 1.0
`default_nettype none

module alu_unit_decode
    import alu_pkg::*;
(
    input  logic [1:0] sel,
    input  logic       issue,
    output logic [3:0] en
);

    always_comb begin
        en = 4'b0000;
        if (issue) begin
            case (sel)
                UNIT_ARITH: en = 4'b0001;
                UNIT_LOG:   en = 4'b0010;
                UNIT_CMP:   en = 4'b0100;
                UNIT_SHIFT: en = 4'b1000;
                default:    en = 4'b0000;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU command to its unit, waits UNIT_LAT, returns the result.
// Optional ALU_SEQ_STATUS_EN adds res_zero/res_err. Revision 1.0
`default_nettype none

module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int width    = 16,
    parameter int UNIT_LAT = 1
) (
    input  logic             clk,
    input  logic             rest,
    alu_op_sequencer_if.slave bus,
    output logic [width-1:0] unit_A,
    output logic [width-1:0] unit_B,
    output logic [1:0]       unit_fun,
    output logic             arith_EN,
    output logic             log_EN,
    output logic             cmp_EN,
    output logic             shift_EN,
    input  logic [width-1:0] arith_out,
    input  logic [width-1:0] log_out,
    input  logic [width-1:0] cmp_out,
    input  logic [width-1:0] shift_out,
    input  logic             arith_flag,
    input  logic             log_flag,
    input  logic             cmp_flag,
    input  logic             shift_flag
);

    localparam int CNT_W = $clog2(UNIT_LAT + 1);

    seq_state_t       state, state_nxt;
    logic [1:0]       unit_sel, unit_sel_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             flag_seen, flag_seen_nxt;
    logic [width-1:0] a_nxt, b_nxt, data_nxt, sel_out, capture;
    logic [1:0]       fun_nxt;
    logic             sel_flag;
    logic             accept;
    logic [3:0]       en_nxt;
`ifdef ALU_SEQ_STATUS_EN
    logic             zero_nxt, err_nxt;
`endif

    assign accept = (state == ST_IDLE) && bus.cmd_valid;

    // Enables are decoded from the incoming command so they can be registered into ISSUE.
    alu_unit_decode u_decode (
        .sel   (bus.cmd_fun[3:2]),
        .issue (accept),
        .en    (en_nxt)
    );

    always_comb begin
        sel_out  = arith_out;
        sel_flag = arith_flag;
        case (unit_sel)
            UNIT_ARITH: begin sel_out = arith_out; sel_flag = arith_flag; end
            UNIT_LOG:   begin sel_out = log_out;   sel_flag = log_flag;   end
            UNIT_CMP:   begin sel_out = cmp_out;   sel_flag = cmp_flag;   end
            UNIT_SHIFT: begin sel_out = shift_out; sel_flag = shift_flag; end
            default:    begin sel_out = arith_out; sel_flag = arith_flag; end
        endcase
    end

    assign capture = flag_seen ? sel_out : '0;

    always_comb begin
        state_nxt     = state;
        unit_sel_nxt  = unit_sel;
        cnt_nxt       = cnt;
        flag_seen_nxt = flag_seen;
        a_nxt         = unit_A;
        b_nxt         = unit_B;
        fun_nxt       = unit_fun;
        data_nxt      = bus.res_data;
`ifdef ALU_SEQ_STATUS_EN
        zero_nxt      = bus.res_zero;
        err_nxt       = bus.res_err;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    a_nxt        = bus.cmd_a;
                    b_nxt        = bus.cmd_b;
                    fun_nxt      = bus.cmd_fun[1:0];
                    unit_sel_nxt = bus.cmd_fun[3:2];
                    state_nxt    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                flag_seen_nxt = sel_flag;
                cnt_nxt       = CNT_W'(UNIT_LAT);
                state_nxt     = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    data_nxt  = capture;
`ifdef ALU_SEQ_STATUS_EN
                    zero_nxt  = (capture == '0);
                    err_nxt   = ~flag_seen;
`endif
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
`ifdef ALU_SEQ_STATUS_EN
                    zero_nxt  = 1'b0;
                    err_nxt   = 1'b0;
`endif
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state         <= ST_IDLE;
            unit_sel      <= 2'b00;
            cnt           <= '0;
            flag_seen     <= 1'b0;
            unit_A        <= '0;
            unit_B        <= '0;
            unit_fun      <= 2'b00;
            arith_EN      <= 1'b0;
            log_EN        <= 1'b0;
            cmp_EN        <= 1'b0;
            shift_EN      <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
`ifdef ALU_SEQ_STATUS_EN
            bus.res_zero  <= 1'b0;
            bus.res_err   <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            unit_sel      <= unit_sel_nxt;
            cnt           <= cnt_nxt;
            flag_seen     <= flag_seen_nxt;
            unit_A        <= a_nxt;
            unit_B        <= b_nxt;
            unit_fun      <= fun_nxt;
            arith_EN      <= en_nxt[0];
            log_EN        <= en_nxt[1];
            cmp_EN        <= en_nxt[2];
            shift_EN      <= en_nxt[3];
            bus.cmd_ready <= (state_nxt == ST_IDLE);
            bus.res_valid <= (state_nxt == ST_DONE);
            bus.res_data  <= data_nxt;
`ifdef ALU_SEQ_STATUS_EN
            bus.res_zero  <= zero_nxt;
            bus.res_err   <= err_nxt;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: bench for alu_op_sequencer with behavioural ALU unit models.
// Revision 1.0
`default_nettype none

module tb_alu_op_sequencer;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n, rst3_n;
    logic kill1 = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_op_sequencer_if #(.width(16)) bus1 ();
    alu_op_sequencer_if #(.width(16)) bus3 ();

    logic [15:0] ua1, ub1, ua3, ub3;
    logic [1:0]  uf1, uf3;
    logic [3:0]  en1, en3, flag1, flag3;
    logic [15:0] out1 [4];
    logic [15:0] out3 [4];
    logic [15:0] st1 [4][LAT1];
    logic [15:0] st3 [4][LAT3];

    assign flag1 = en1 & {4{~kill1}};
    assign flag3 = en3;

    alu_op_sequencer #(.width(16), .UNIT_LAT(LAT1)) dut1 (
        .clk(clk), .rest(rst1_n), .bus(bus1),
        .unit_A(ua1), .unit_B(ub1), .unit_fun(uf1),
        .arith_EN(en1[0]), .log_EN(en1[1]), .cmp_EN(en1[2]), .shift_EN(en1[3]),
        .arith_out(out1[0]), .log_out(out1[1]), .cmp_out(out1[2]), .shift_out(out1[3]),
        .arith_flag(flag1[0]), .log_flag(flag1[1]), .cmp_flag(flag1[2]), .shift_flag(flag1[3])
    );

    alu_op_sequencer #(.width(16), .UNIT_LAT(LAT3)) dut3 (
        .clk(clk), .rest(rst3_n), .bus(bus3),
        .unit_A(ua3), .unit_B(ub3), .unit_fun(uf3),
        .arith_EN(en3[0]), .log_EN(en3[1]), .cmp_EN(en3[2]), .shift_EN(en3[3]),
        .arith_out(out3[0]), .log_out(out3[1]), .cmp_out(out3[2]), .shift_out(out3[3]),
        .arith_flag(flag3[0]), .log_flag(flag3[1]), .cmp_flag(flag3[2]), .shift_flag(flag3[3])
    );

    // Functional definition of the four ALU units.
    function automatic logic [15:0] calc(input logic [1:0] u, input logic [1:0] f,
                                         input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        r = 16'h0;
        case (u)
            2'd0: case (f)
                2'd0: r = a + b;
                2'd1: r = a - b;
                2'd2: r = a + 16'd1;
                default: r = a - 16'd1;
            endcase
            2'd1: case (f)
                2'd0: r = a & b;
                2'd1: r = a | b;
                2'd2: r = ~(a & b);
                default: r = ~(a | b);
            endcase
            2'd2: case (f)
                2'd0: r = {15'd0, a == b};
                2'd1: r = {15'd0, a < b};
                2'd2: r = {15'd0, a > b};
                default: r = {15'd0, $signed(a) < $signed(b)};
            endcase
            default: case (f)
                2'd0: r = a << b[3:0];
                2'd1: r = a >> b[3:0];
                2'd2: r = $unsigned($signed(a) >>> b[3:0]);
                default: r = (a << b[3:0]) | (a >> (5'd16 - {1'b0, b[3:0]}));
            endcase
        endcase
        return r;
    endfunction

    // Unit models: result enters on the enable edge, reaches the output register after LAT edges.
    always @(posedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (en1[u]) st1[u][0] <= calc(2'(u), uf1, ua1, ub1);
            for (int k = 1; k < LAT1; k++) st1[u][k] <= st1[u][k-1];
            if (en3[u]) st3[u][0] <= calc(2'(u), uf3, ua3, ub3);
            for (int k = 1; k < LAT3; k++) st3[u][k] <= st3[u][k-1];
        end
    end

    always_comb begin
        for (int u = 0; u < 4; u++) begin
            out1[u] = st1[u][LAT1-1];
            out3[u] = st3[u][LAT3-1];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transaction on dut1; entered and left at a falling edge with dut1 idle.
    task automatic op1(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input bit kill);
        logic [15:0] exp;
        logic [3:0]  exp_en;
        exp    = kill ? 16'h0 : calc(f[3:2], f[1:0], a, b);
        exp_en = 4'b0001 << f[3:2];
        kill1          = kill;
        bus1.cmd_fun   = f;
        bus1.cmd_a     = a;
        bus1.cmd_b     = b;
        bus1.cmd_valid = 1'b1;
        bus1.res_ready = 1'b0;
        check("idle_ready", {31'd0, bus1.cmd_ready}, 32'd1);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        check("issue_en", {28'd0, en1}, {28'd0, exp_en});
        check("issue_ready", {31'd0, bus1.cmd_ready}, 32'd0);
        check("issue_a", {16'd0, ua1}, {16'd0, a});
        check("issue_fun", {30'd0, uf1}, {30'd0, f[1:0]});
        for (int k = 0; k < LAT1; k++) begin
            @(negedge clk);
            check("wait_en", {28'd0, en1}, 32'd0);
            check("wait_valid", {31'd0, bus1.res_valid}, 32'd0);
            check("wait_b", {16'd0, ub1}, {16'd0, b});
        end
        @(negedge clk);
        check("done_valid", {31'd0, bus1.res_valid}, 32'd1);
        check("done_data", {16'd0, bus1.res_data}, {16'd0, exp});
`ifdef ALU_SEQ_STATUS_EN
        check("done_zero", {31'd0, bus1.res_zero}, {31'd0, exp == 16'h0});
        check("done_err", {31'd0, bus1.res_err}, {31'd0, kill});
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, bus1.res_valid}, 32'd1);
            check("hold_data", {16'd0, bus1.res_data}, {16'd0, exp});
            check("hold_ready", {31'd0, bus1.cmd_ready}, 32'd0);
        end
        bus1.res_ready = 1'b1;
        @(negedge clk);
        check("leave_valid", {31'd0, bus1.res_valid}, 32'd0);
        check("leave_ready", {31'd0, bus1.cmd_ready}, 32'd1);
`ifdef ALU_SEQ_STATUS_EN
        check("leave_err", {31'd0, bus1.res_err}, 32'd0);
`endif
        bus1.res_ready = 1'b0;
        kill1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  f;
        logic [15:0] a, b, exp;
        int          t_acc, t_prev, ncyc, guard;

        rst1_n = 1'b0;
        rst3_n = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_fun = 4'h0; bus1.cmd_a = 16'h0; bus1.cmd_b = 16'h0;
        bus1.res_ready = 1'b0;
        bus3.cmd_valid = 1'b0; bus3.cmd_fun = 4'h0; bus3.cmd_a = 16'h0; bus3.cmd_b = 16'h0;
        bus3.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_ready", {31'd0, bus1.cmd_ready}, 32'd1);
        check("rst_en", {28'd0, en1}, 32'd0);
        check("rst_valid", {31'd0, bus1.res_valid}, 32'd0);
        check("rst_data", {16'd0, bus1.res_data}, 32'd0);
        check("rst_ops", {ua1, ub1}, 32'd0);
        check("rst_fun", {30'd0, uf1}, 32'd0);
        check("rst3_ready", {31'd0, bus3.cmd_ready}, 32'd1);

        // Directed: logic AND, NOR with backpressure, unflagged op
        op1(4'b0100, 16'h00FF, 16'h0F0F, 0, 1'b0);
        op1(4'b0111, 16'h0000, 16'h0000, 5, 1'b0);
        op1(4'b0001, 16'h1234, 16'h0101, 1, 1'b1);

        // Randomized transactions
        for (int i = 0; i < 16; i++) begin
            op1(4'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0));
        end

        // Reset pulsed during WAIT abandons the command
        bus1.cmd_fun = 4'b0000; bus1.cmd_a = 16'h1111; bus1.cmd_b = 16'h2222;
        bus1.cmd_valid = 1'b1;
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        @(negedge clk);
        #1 rst1_n = 1'b0;
        #1;
        check("arst_en", {28'd0, en1}, 32'd0);
        check("arst_valid", {31'd0, bus1.res_valid}, 32'd0);
        check("arst_ready", {31'd0, bus1.cmd_ready}, 32'd1);
        check("arst_ops", {ua1, ub1}, 32'd0);
        @(negedge clk);
        rst1_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("arst_no_result", {31'd0, bus1.res_valid}, 32'd0);
        end
        op1(4'b1100, 16'h0003, 16'h0004, 0, 1'b0);

        // Back-to-back commands on the UNIT_LAT=3 instance
        bus3.res_ready = 1'b1;
        f = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
        bus3.cmd_fun = f; bus3.cmd_a = a; bus3.cmd_b = b; bus3.cmd_valid = 1'b1;
        ncyc = 0;
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            exp = calc(f[3:2], f[1:0], a, b);
            guard = 0;
            while (!bus3.cmd_ready && guard < 20) begin
                @(negedge clk); ncyc++; guard++;
            end
            check("b2b_ready_wait", {31'd0, bus3.cmd_ready}, 32'd1);
            t_acc = ncyc;
            if (i > 0) check("b2b_spacing", t_acc - t_prev, LAT3 + 3);
            t_prev = t_acc;
            @(negedge clk); ncyc++;
            check("b2b_issue_en", {28'd0, en3}, {28'd0, 4'b0001 << f[3:2]});
            f = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
            bus3.cmd_fun = f; bus3.cmd_a = a; bus3.cmd_b = b;
            guard = 0;
            while (!bus3.res_valid && guard < 20) begin
                @(negedge clk); ncyc++; guard++;
            end
            check("b2b_valid_wait", {31'd0, bus3.res_valid}, 32'd1);
            check("b2b_latency", ncyc - t_acc, LAT3 + 2);
            check("b2b_data", {16'd0, bus3.res_data}, {16'd0, exp});
            @(negedge clk); ncyc++;
        end
        bus3.cmd_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
